// File: rtl/sqrt_range_reduce.sv
// sqrt_range_reduce: f = sqrt(e) for the Box-Muller f-path.
// Normalises e (Q7.24) to an even-exponent mantissa in [1,4), then takes a
// bit-serial restoring square root. The result is y_f (Q1.19) * 2^exp_ff.
module sqrt_range_reduce #(
    parameter int E_W    = 31,
    parameter int E_FRAC = 24,
    parameter int Y_W    = 20
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [E_W-1:0] e_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Y_W-1:0] y_f,
    output logic [4:0]     exp_ff
);

    localparam int R_W   = 2 * Y_W;          // radicand width
    localparam int K_W   = $clog2(E_W);      // leading-one index width
    localparam int S_W   = $clog2(R_W);      // shift amount width
    localparam int C_W   = $clog2(Y_W);      // iteration counter width
    localparam int EXP_W = 5;

    localparam logic signed [7:0]     FRAC_S  = 8'(E_FRAC);
    localparam logic [S_W-1:0]        SH_BASE = S_W'(R_W - 2);
    localparam logic [C_W-1:0]        LAST    = C_W'(Y_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        SQRT,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [E_W-1:0]        e_q, e_d;
    logic [R_W-1:0]        rad_q, rad_d;
    logic [Y_W+1:0]        rem_q, rem_d;
    logic [Y_W-1:0]        root_q, root_d;
    logic [C_W-1:0]        cnt_q, cnt_d;
    logic [EXP_W-1:0]      exp_q, exp_d;
    logic [Y_W-1:0]        y_f_q, y_f_d;
    logic [EXP_W-1:0]      exp_ff_q, exp_ff_d;

    logic [K_W-1:0]        lead;
    logic signed [7:0]     e_raw;
    logic [S_W-1:0]        shamt;
    logic [R_W-1:0]        rad_norm;
    logic [Y_W+3:0]        rem_sh;
    logic [Y_W+4:0]        trial;
    logic [Y_W+1:0]        rem_nxt;
    logic [Y_W-1:0]        root_nxt;

    // Leading-one detector plus shift/exponent selection for range reduction.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        lead = '0;
        for (int i = 0; i < E_W; i++) begin
            if (e_q[i]) lead = K_W'(i);
        end
        e_raw = $signed({3'b000, lead}) - FRAC_S;
        // An odd raw exponent takes one extra left shift so the exponent stays even.
        shamt    = SH_BASE - S_W'(lead) + S_W'(e_raw[0]);
        rad_norm = R_W'(e_q) << shamt;
    end

    // One restoring square-root step: bring down two radicand bits, try to subtract.
    always_comb begin
        rem_sh = {rem_q, rad_q[R_W-1 -: 2]};
        trial  = {1'b0, rem_sh} - {3'b000, root_q, 2'b01};
        if (!trial[Y_W+4]) begin
            rem_nxt  = trial[Y_W+1:0];
            root_nxt = {root_q[Y_W-2:0], 1'b1};
        end else begin
            rem_nxt  = rem_sh[Y_W+1:0];
            root_nxt = {root_q[Y_W-2:0], 1'b0};
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        e_d      = e_q;
        rad_d    = rad_q;
        rem_d    = rem_q;
        root_d   = root_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        y_f_d    = y_f_q;
        exp_ff_d = exp_ff_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    e_d     = e_in;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (e_q == '0) begin
                    y_f_d    = '0;
                    exp_ff_d = '0;
                    state_d  = DONE;
                end else begin
                    rad_d   = rad_norm;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = '0;
                    // Arithmetic shift floors, which is E/2 once E has been made even.
                    exp_d   = EXP_W'(e_raw >>> 1);
                    state_d = SQRT;
                end
            end
            SQRT: begin
                rad_d  = rad_q << 2;
                rem_d  = rem_nxt;
                root_d = root_nxt;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    y_f_d    = root_nxt;
                    exp_ff_d = exp_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            e_q      <= '0;
            rad_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            y_f_q    <= '0;
            exp_ff_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            e_q      <= e_d;
            rad_q    <= rad_d;
            rem_q    <= rem_d;
            root_q   <= root_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            y_f_q    <= y_f_d;
            exp_ff_q <= exp_ff_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y_f       = y_f_q;
    assign exp_ff    = exp_ff_q;

endmodule

// File: tb/tb_sqrt_range_reduce.sv
// Self-checking bench for sqrt_range_reduce: directed corner values, output hold,
// mid-operation reset and randomized samples against an arithmetic reference model.
module tb_sqrt_range_reduce;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [30:0] e_in;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] y_f;
    logic [4:0]  exp_ff;

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    sqrt_range_reduce dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .e_in      (e_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_f       (y_f),
        .exp_ff    (exp_ff)
    );

    always #5 clk = ~clk;

    // Handshake signals must never both be high.
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (in_ready && out_valid) begin
                n_fail++;
                $display("FAIL excl_ready_valid: in_ready=%0b out_valid=%0b, required not both 1 (t=%0t)",
                         in_ready, out_valid, $time);
            end
        end
    end

    // Reference: e = m * 2^E with E even and m in [1,4); y = floor(sqrt(m * 2^38)).
    function automatic void model(input logic [30:0] e, output logic [19:0] y, output logic [4:0] x);
        int     k;
        int     ev;
        longint r;
        longint t;
        if (e == 0) begin
            y = '0;
            x = '0;
            return;
        end
        k = 0;
        while ((longint'(e) >> (k + 1)) != 0) k++;
        ev = (k - 24) - ((k - 24) & 1);
        r  = longint'(e) << (14 - ev);
        y  = '0;
        for (int b = 19; b >= 0; b--) begin
            t = longint'(y) | (longint'(1) << b);
            if (t * t <= r) y = 20'(t);
        end
        x = 5'(ev / 2);
    endfunction

    task automatic apply_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        e_in      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Present e for one accepted handshake; returns at the negedge after the accept edge.
    task automatic start(input logic [30:0] e, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        in_valid = 1'b1;
        e_in     = e;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        e_in     = 31'($urandom);
    endtask

    // lat = index of the edge (accept edge = 0) at which a consumer first sees out_valid.
    task automatic wait_valid(output int lat, output bit ok);
        lat = 1;
        ok  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting for handshake, required completion", name);
        apply_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp += 4;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        if (y_f !== 20'h0) begin n_fail++; $display("FAIL reset_y_f: got %h want 0", y_f); end
        if (exp_ff !== 5'h0) begin n_fail++; $display("FAIL reset_exp_ff: got %b want 0", exp_ff); end
    endtask

    task automatic test_directed();
        logic [30:0] tv_e   [6] = '{31'h1000000, 31'h2000000, 31'h4000000, 31'h7FFFFFFF, 31'h1, 31'h0};
        logic [19:0] tv_y   [6] = '{20'h80000, 20'hB504F, 20'h80000, 20'hB504F, 20'h80000, 20'h0};
        logic [4:0]  tv_x   [6] = '{5'b00000, 5'b00000, 5'b00001, 5'b00011, 5'b10100, 5'b00000};
        int          tv_lat [6] = '{22, 22, 22, 22, 22, 2};
        int lat;
        bit ok;
        for (int i = 0; i < 6; i++) begin
            start(tv_e[i], ok);
            if (ok) wait_valid(lat, ok);
            if (!ok) begin timeout_fail("directed"); continue; end
            n_cmp += 3;
            if (y_f !== tv_y[i]) begin n_fail++; $display("FAIL dir_y_f e=%h: got %h want %h", tv_e[i], y_f, tv_y[i]); end
            if (exp_ff !== tv_x[i]) begin n_fail++; $display("FAIL dir_exp_ff e=%h: got %b want %b", tv_e[i], exp_ff, tv_x[i]); end
            if (lat != tv_lat[i]) begin n_fail++; $display("FAIL dir_latency e=%h: got %0d want %0d", tv_e[i], lat, tv_lat[i]); end
            release_out();
            n_cmp += 3;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir_valid_drop e=%h: got %0b want 0", tv_e[i], out_valid); end
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir_idle_ready e=%h: got %0b want 1", tv_e[i], in_ready); end
            if (y_f !== tv_y[i]) begin n_fail++; $display("FAIL dir_idle_hold e=%h: got %h want %h", tv_e[i], y_f, tv_y[i]); end
        end
    endtask

    task automatic test_hold();
        int lat;
        bit ok;
        bit bad;
        start(31'h2000000, ok);
        if (ok) wait_valid(lat, ok);
        if (!ok) begin timeout_fail("hold"); return; end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            e_in     = 31'h4000000;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || y_f !== 20'hB504F || exp_ff !== 5'b00000) begin
                n_fail++;
                bad = 1'b1;
                $display("FAIL hold_cycle%0d: valid=%0b ready=%0b y=%h exp=%b want 1 0 b504f 00000",
                         i, out_valid, in_ready, y_f, exp_ff);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        release_out();
        repeat (3) @(negedge clk);
        n_cmp += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_ignored_in_valid: out_valid got %0b want 0", out_valid); end
        if (y_f !== 20'hB504F) begin n_fail++; $display("FAIL hold_idle_y_f: got %h want b504f", y_f); end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit ok;
        bit seen;
        logic [19:0] ey;
        logic [4:0]  ex;
        start(31'h7FFFFFFF, ok);
        if (!ok) begin timeout_fail("reset_mid"); return; end
        // Now after the accept edge (NORM); five more edges put the FSM in SQRT cycle 5.
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_cmp += 4;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %0b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %0b want 0", out_valid); end
        if (y_f !== 20'h0) begin n_fail++; $display("FAIL midrst_y_f: got %h want 0", y_f); end
        if (exp_ff !== 5'h0) begin n_fail++; $display("FAIL midrst_exp_ff: got %b want 0", exp_ff); end
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin n_fail++; $display("FAIL midrst_no_result: out_valid seen 1, want aborted sample"); end
        model(31'h1000000, ey, ex);
        start(31'h1000000, ok);
        if (ok) wait_valid(lat, ok);
        if (!ok) begin timeout_fail("reset_recover"); return; end
        n_cmp += 2;
        if (y_f !== ey) begin n_fail++; $display("FAIL midrst_recover_y: got %h want %h", y_f, ey); end
        if (exp_ff !== ex) begin n_fail++; $display("FAIL midrst_recover_exp: got %b want %b", exp_ff, ex); end
        release_out();
    endtask

    task automatic test_random(input int n);
        logic [30:0] e;
        logic [19:0] ey;
        logic [4:0]  ex;
        int          lat;
        int          xs;
        bit          ok;
        real         got_r;
        real         ref_r;
        real         lsb;
        for (int i = 0; i < n; i++) begin
            e = 31'($urandom) >> $urandom_range(0, 30);
            model(e, ey, ex);
            start(e, ok);
            if (ok) wait_valid(lat, ok);
            if (!ok) begin timeout_fail("random"); continue; end
            n_cmp += 3;
            if (y_f !== ey) begin n_fail++; $display("FAIL rnd_y_f e=%h: got %h want %h", e, y_f, ey); end
            if (exp_ff !== ex) begin n_fail++; $display("FAIL rnd_exp_ff e=%h: got %b want %b", e, exp_ff, ex); end
            if (lat != ((e == 0) ? 2 : 22)) begin n_fail++; $display("FAIL rnd_latency e=%h: got %0d want %0d", e, lat, (e == 0) ? 2 : 22); end
            if (e != 0) begin
                xs    = $signed(exp_ff);
                lsb   = 2.0 ** real'(xs - 19);
                got_r = real'(y_f) * lsb;
                ref_r = $sqrt(real'(e) / (2.0 ** 24));
                n_cmp++;
                if (y_f[19] !== 1'b1 || got_r > ref_r + lsb || got_r < ref_r - lsb) begin
                    n_fail++;
                    $display("FAIL rnd_accuracy e=%h: got %f want %f within %g", e, got_r, ref_r, lsb);
                end
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release_out();
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        e_in      = '0;
        test_reset();
        mon_en = 1'b1;
        test_directed();
        test_hold();
        mon_en = 1'b0;
        test_reset_mid();
        mon_en = 1'b1;
        test_random(1500);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
